mpr_restore: RTL
================

# mpr_restore

Restores parked thread contexts from the memory-parked-register (MPR) slot storage back into the core register file. Tracks which 9-bit conflicted address each of the 4 slots waits on, and marks a slot pending when that address is freed. Arbitrates among pending slots round-robin, handshakes with the core for a restore window, then streams 15 × 32-bit registers out of slot storage into the core. Sits between the MPR save path (writer) and the core register file (reader side of the same context-switch interface).

## Interface
- `NUM_SLOTS`, 4: parked-context slots.
- `NUM_REGS`, 15: registers per context.
- `ADDR_W`, 9: conflicted-address width.
- `DATA_W`, 32: register width.
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `park_valid`, in, 1: save path parked a context this cycle.
- `park_slot`, in, 2: slot written.
- `park_addr`, in, `ADDR_W`: address that slot waits on.
- `freed_valid`, in, 1: an address was freed.
- `freed_addr`, in, `ADDR_W`: freed address.
- `freed_miss`, out, 1: pulse; freed address matched no waiting slot.
- `park_err`, out, 1: pulse; park targeted the slot being restored, and was ignored.
- `restore_req`, out, 1: request for a restore window.
- `restore_grant`, in, 1: core accepts; sampled only while `restore_req`=1.
- `rd_slot`, out, 2: slot storage read port, slot select.
- `rd_idx`, out, 4: slot storage read port, register index.
- `rd_en`, out, 1: read strobe.
- `rd_data`, in, `DATA_W`: valid exactly 1 cycle after `rd_en`.
- `wr_en`, out, 1: core register-file write strobe.
- `wr_idx`, out, 4: core register-file write index.
- `wr_data`, out, `DATA_W`: core register-file write data.
- `restore_done`, out, 1: 1-cycle pulse after the last write.
- `release_valid`, out, 1: 1-cycle pulse, coincident with `restore_done`; the slot is free for reuse by the save path.
- `release_slot`, out, 2: slot being released.

## Operation
- Per-slot state: `waiting`, `pending`, `addr`.
- Park: sets `waiting`=1, clears `pending`, stores `addr`.
  - Overwrites any prior content of the slot.
  - Ignored with `park_err` if the slot is the active restore slot.
- Freed: compared against the registered table.
  - Every slot with `waiting`=1 and an equal `addr` moves to `pending`=1, `waiting`=0. Multiple matches are all marked.
  - No match: `freed_miss` pulses the next cycle.
  - A park and a freed in the same cycle with the same address: the park is recorded and the freed does not match it.
- FSM:
  - IDLE: if any slot is pending → REQ. The winner is chosen by a 4-way round-robin arbiter, starting from the slot after the last one restored, and latched as `cur`.
  - REQ: `restore_req`=1; hold until `restore_grant` → STREAM.
  - STREAM: issue reads for `rd_idx` 0..14 on consecutive cycles. Each `rd_data` is written out the following cycle as `wr_en`=1 with `wr_idx` equal to the read index of the previous cycle. After the last write → DONE.
  - DONE: pulse `restore_done` and `release_valid` (`release_slot`=`cur`); clear `pending[cur]`; advance the round-robin pointer → IDLE.
- A freed address that matches `cur` during a restore has no effect, because `cur` is neither waiting nor re-parkable.

## Timing
- Reset values: all outputs 0; table cleared; round-robin pointer = 0; FSM = IDLE.
- Reset asserted mid-restore aborts immediately. No `restore_done`, and the slot is not released.
- Freed at cycle t → pending visible at t+1 → `restore_req` no earlier than t+2.
- Grant sampled at cycle g:
  - `rd_en` at g+1 … g+15.
  - `wr_en` at g+2 … g+16.
  - `restore_done` at g+17.
  - Next `restore_req` no earlier than g+18.
- `restore_req` stays high until granted; there is no timeout.
- `restore_grant` while `restore_req`=0 is ignored.
- `rd_en` is never asserted outside STREAM.
- `wr_idx` increments 0→14 without gaps; the 4-bit index never reaches 15.

## Structure
- Shared package `mpr_pkg`:
  - Constants `NUM_SLOTS`, `NUM_REGS`, `ADDR_W`, `DATA_W`.
  - `slot_id_t` (2 bits), `reg_idx_t` (4 bits).
  - `restore_state_t` enum {IDLE, REQ, STREAM, DONE}.
- One sub-module: `rr_arbiter4`.
  - Inputs: 4-bit request, 2-bit pointer.
  - Outputs: grant index, any-valid.
  - Purely combinational; the pointer register lives in `mpr_restore`.

## Test plan
- Reset then idle: all outputs 0; `freed_valid` with `freed_addr`=0x1A3 and an empty table → `freed_miss` pulse 1 cycle later; no `restore_req`.
- Single restore: park slot 2 at addr 0x055; free 0x055; grant on the first `restore_req` cycle. Storage returns 0xA000_0000+idx → 15 writes, idx 0..14 with matching data, on grant+2..+16. `restore_done` and `release_valid` with `release_slot`=2 at grant+17.
- Round-robin: park slots 0, 1, 3 all at addr 0x100; one freed 0x100 → restores in order 0, 1, 3, each separated by a DONE → IDLE → REQ sequence.
- Delayed grant: `restore_grant` held low 10 cycles → `restore_req` stays high, no `rd_en`. Grant on cycle 11 → the stream starts on the next cycle.
- Same-cycle park and freed: park slot 1 at addr 0x0F0 and freed 0x0F0 in the same cycle → slot 1 stays waiting; `freed_miss`=1. A later freed 0x0F0 triggers the restore.
- Mid-stream events: during the restore of slot 0, park slot 0 → `park_err`, table unchanged. Assert `rst_n`=0 at write 7 → outputs 0 immediately; no `restore_done`; table empty after release of reset.

Source files
------------

// File: rtl/mpr_pkg.sv
// Shared types and sizing for the MPR context-restore path.
package mpr_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int NUM_REGS  = 15;
    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 32;

    typedef logic [1:0] slot_id_t;
    typedef logic [3:0] reg_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        STREAM,
        DONE
    } restore_state_t;

    // Stream counter value reached after the last read has been issued.
    localparam reg_idx_t STREAM_END = reg_idx_t'(NUM_REGS);

endpackage

// File: rtl/mpr_restore_if.sv
// Context-switch bus between the MPR save path, slot storage and the core register file.
interface mpr_restore_if;
    import mpr_pkg::*;

    logic                  park_valid;
    slot_id_t              park_slot;
    logic [ADDR_W-1:0]     park_addr;
    logic                  freed_valid;
    logic [ADDR_W-1:0]     freed_addr;
    logic                  freed_miss;
    logic                  park_err;
    logic                  restore_req;
    logic                  restore_grant;
    slot_id_t              rd_slot;
    reg_idx_t              rd_idx;
    logic                  rd_en;
    logic [DATA_W-1:0]     rd_data;
    logic                  wr_en;
    reg_idx_t              wr_idx;
    logic [DATA_W-1:0]     wr_data;
    logic                  restore_done;
    logic                  release_valid;
    slot_id_t              release_slot;

    modport master (
        input  park_valid, park_slot, park_addr, freed_valid, freed_addr,
        input  restore_grant, rd_data,
        output freed_miss, park_err, restore_req, rd_slot, rd_idx, rd_en,
        output wr_en, wr_idx, wr_data, restore_done, release_valid, release_slot
    );

    modport slave (
        output park_valid, park_slot, park_addr, freed_valid, freed_addr,
        output restore_grant, rd_data,
        input  freed_miss, park_err, restore_req, rd_slot, rd_idx, rd_en,
        input  wr_en, wr_idx, wr_data, restore_done, release_valid, release_slot
    );

endinterface

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick: first request at or after ptr, wrapping.
module rr_arbiter4
    import mpr_pkg::*;
(
    input  logic [3:0] req,
    input  slot_id_t   ptr,
    output slot_id_t   gnt,
    output logic       any
);

    slot_id_t cand;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        gnt  = '0;
        cand = '0;
        for (int i = 3; i >= 0; i--) begin
            cand = slot_id_t'(int'(ptr) + i);
            if (req[cand]) begin
                gnt = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mpr_restore.sv
// Tracks parked slots waiting on freed addresses and streams pending contexts back to the core.
//   state  | meaning
//   IDLE   | no restore active; pick a pending slot round-robin
//   REQ    | restore_req high, waiting for restore_grant
//   STREAM | reads idx 0..14, each written to the core one cycle later
//   DONE   | restore_done/release pulse, clear pending, advance pointer
module mpr_restore
    import mpr_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    mpr_restore_if.master bus
);

    restore_state_t        state, state_nxt;
    slot_id_t              cur;
    slot_id_t              rr_ptr;
    reg_idx_t              cnt;

    logic [NUM_SLOTS-1:0]  waiting;
    logic [NUM_SLOTS-1:0]  pending;
    logic [ADDR_W-1:0]     addr_q [NUM_SLOTS];

    logic [NUM_SLOTS-1:0]  match;
    logic                  park_ok;
    slot_id_t              arb_gnt;
    logic                  arb_any;

    logic                  freed_miss_q;
    logic                  park_err_q;
    logic                  wr_en_q;
    reg_idx_t              wr_idx_q;

    logic                  restore_req_c;
    logic                  rd_en_c;
    reg_idx_t              rd_idx_c;
    slot_id_t              rd_slot_c;
    logic                  done_c;
    slot_id_t              release_slot_c;

    rr_arbiter4 u_arb (
        .req (pending),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .any (arb_any)
    );

    // The active slot (latched in REQ, held through DONE) cannot be re-parked.
    assign park_ok = bus.park_valid && !((state != IDLE) && (bus.park_slot == cur));

    // A same-cycle park takes the slot, so the freed address cannot match it.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            match[i] = bus.freed_valid && waiting[i] && (addr_q[i] == bus.freed_addr)
                       && !(park_ok && (bus.park_slot == slot_id_t'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waiting      <= '0;
            pending      <= '0;
            freed_miss_q <= 1'b0;
            park_err_q   <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (park_ok && (bus.park_slot == slot_id_t'(i))) begin
                    waiting[i] <= 1'b1;
                    pending[i] <= 1'b0;
                    addr_q[i]  <= bus.park_addr;
                end else if (match[i]) begin
                    waiting[i] <= 1'b0;
                    pending[i] <= 1'b1;
                end else if ((state == DONE) && (cur == slot_id_t'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
            freed_miss_q <= bus.freed_valid && (match == '0);
            park_err_q   <= bus.park_valid && !park_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_any) state_nxt = REQ;
            REQ:     if (bus.restore_grant) state_nxt = STREAM;
            STREAM:  if (cnt == STREAM_END) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        restore_req_c  = (state == REQ);
        rd_en_c        = (state == STREAM) && (cnt != STREAM_END);
        rd_idx_c       = rd_en_c ? cnt : '0;
        rd_slot_c      = rd_en_c ? cur : '0;
        done_c         = (state == DONE);
        release_slot_c = done_c ? cur : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
            wr_en_q  <= 1'b0;
            wr_idx_q <= '0;
        end else begin
            if ((state == IDLE) && arb_any) begin
                cur <= arb_gnt;
            end
            if (state == DONE) begin
                rr_ptr <= cur + 2'd1;
            end
            if (state != STREAM) begin
                cnt <= '0;
            end else if (cnt != STREAM_END) begin
                cnt <= cnt + 4'd1;
            end
            wr_en_q  <= rd_en_c;
            wr_idx_q <= rd_idx_c;
        end
    end

    assign bus.freed_miss    = freed_miss_q;
    assign bus.park_err      = park_err_q;
    assign bus.restore_req   = restore_req_c;
    assign bus.rd_en         = rd_en_c;
    assign bus.rd_idx        = rd_idx_c;
    assign bus.rd_slot       = rd_slot_c;
    assign bus.wr_en         = wr_en_q;
    assign bus.wr_idx        = wr_idx_q;
    // Storage data arrives one cycle after the read, aligned with wr_en.
    assign bus.wr_data       = wr_en_q ? bus.rd_data : '0;
    assign bus.restore_done  = done_c;
    assign bus.release_valid = done_c;
    assign bus.release_slot  = release_slot_c;

endmodule
